uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter UART_BPS, default 'd9600, meaning serial baud rate.
REQ-002 SHALL have parameter CLK_FREQ, default 'd50_000_000, meaning clk frequency in Hz.
REQ-003 SHALL have parameter FIFO_RD_WIDTH, default 'd32, meaning read-FIFO data width; legal only when equal to 8*FIFO_RD_BYTE.
REQ-004 SHALL have parameter FIFO_RD_BYTE, default 'd4, meaning bytes per FIFO word.
REQ-005 SHALL have port clk  input  1  system clock, same clock as the read FIFO.
REQ-006 SHALL have port rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-007 SHALL have port fifo_rd_data  input  FIFO_RD_WIDTH  FIFO read data, valid the cycle after fifo_rd_en (standard, non-FWFT FIFO).
REQ-008 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-009 SHALL have port fifo_rd_en  output  1  FIFO read enable, one-cycle pulse per word.
REQ-010 SHALL have port tx  output  1  UART serial line, idle high.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL use bit period N = CLK_FREQ/UART_BPS clocks, integer division (5208 at defaults), with a baud counter counting 0..N-1.
REQ-013 SHALL frame each byte 8N1: start 0, data bits LSB first, stop 1; every bit, including stop, holds exactly N clocks.
REQ-014 SHALL send the bytes of a word most-significant byte first: [W-1:W-8] first, [7:0] last.
REQ-015 SHALL use states IDLE, REQ, LOAD, START, DATA, STOP; all outputs registered.
REQ-016 IDLE: on a rising edge with fifo_empty=0, go to REQ; otherwise stay; tx=1.
REQ-017 REQ: fifo_rd_en=1 for exactly this one cycle; next state LOAD.
REQ-018 LOAD: fifo_rd_en=0; on the edge ending LOAD, latch fifo_rd_data into the word register and clear the byte index; next state START.
REQ-019 START: tx=0 for N clocks; then DATA with bit index 0.
REQ-020 DATA: tx = current byte bit[index] for N clocks each; after index 7 go to STOP.
REQ-021 STOP: tx=1 for N clocks; then, if the byte index is below FIFO_RD_BYTE-1, increment it and go to START (no gap); otherwise go to IDLE.
REQ-022 Latency: tx SHALL fall 2 edges after the IDLE edge that sampled fifo_empty=0.
REQ-023 Back-to-back words: tx SHALL stay high N+3 clocks between the last data bit of one word and the next start bit.
REQ-024 fifo_empty SHALL be ignored in every state except IDLE; fifo_rd_en SHALL never assert while fifo_empty=1 in IDLE.
REQ-025 A word SHALL never be re-read or skipped: exactly one fifo_rd_en pulse per FIFO_RD_BYTE transmitted bytes.
REQ-026 The word register SHALL hold constant from LOAD until the word completes, independent of fifo_rd_data changes.

Reset
REQ-027 While rst_n=0: tx=1, fifo_rd_en=0, busy=0, state IDLE, all counters and indices 0; applied asynchronously.
REQ-028 Reset mid-frame SHALL abort immediately with tx=1; the partly sent word is discarded and not retried.
REQ-029 After rst_n release, the first action SHALL be an IDLE sample of fifo_empty.

Verification
REQ-030 Reset with fifo_empty=1 held -> tx=1, busy=0, no fifo_rd_en pulse for 100000 clocks.
REQ-031 One word 0x12345678 -> one fifo_rd_en pulse; bytes 0x12,0x34,0x56,0x78; first frame line sequence 0,0,1,0,0,1,0,0,0,1, each 5208 clocks; busy high for 2+40*5208 clocks.
REQ-032 Words 0xA5A5A5A5 then 0x00FF00FF, fifo never empty -> exactly 2 rd_en pulses; 8 correct frames; 5208+3 high clocks between the words.
REQ-033 rst_n low during bit 3 of byte 2 -> tx=1 within the same cycle; after release, next word sent from its first byte in full.
REQ-034 fifo_empty toggled every clock while busy -> no fifo_rd_en until IDLE; output unchanged.
REQ-035 Loopback into uart_receiver (UART_BPS 9600, CLK_FREQ 50 MHz, 32-bit words) with 99 random words -> receiver fifo_wr_data sequence identical to the input sequence.

Source files
------------

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter draining a word-wide read FIFO, most significant byte first
// Each FIFO word is read once, held in word_q, and sent as FIFO_RD_BYTE back-to-back frames.

module uart_transmitter #(
    parameter int UART_BPS      = 'd9600,
    parameter int CLK_FREQ      = 'd50_000_000,
    parameter int FIFO_RD_WIDTH = 'd32,
    parameter int FIFO_RD_BYTE  = 'd4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [FIFO_RD_WIDTH-1:0] fifo_rd_data,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    output logic                     tx,
    output logic                     busy
);

    localparam int BAUD_N = CLK_FREQ / UART_BPS;
    localparam int CNT_W  = (BAUD_N > 1) ? $clog2(BAUD_N) : 1;
    localparam int IDX_W  = (FIFO_RD_BYTE > 1) ? $clog2(FIFO_RD_BYTE) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_N - 1);
    localparam logic [IDX_W-1:0] BYTE_LAST = IDX_W'(FIFO_RD_BYTE - 1);

    if (FIFO_RD_WIDTH != 8 * FIFO_RD_BYTE) begin : g_bad_width
        $error("uart_transmitter: FIFO_RD_WIDTH must equal 8*FIFO_RD_BYTE");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                   state_q;
    logic                     tx_q;
    logic                     rd_en_q;
    logic                     busy_q;
    logic [CNT_W-1:0]         baud_cnt_q;
    logic [2:0]               bit_idx_q;
    logic [IDX_W-1:0]         byte_idx_q;
    logic [FIFO_RD_WIDTH-1:0] word_q;

    logic                     baud_done;
    logic [7:0]               cur_byte;

    assign baud_done = (baud_cnt_q == CNT_LAST);

    // Byte index 0 selects the most significant byte of the word.
    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < FIFO_RD_BYTE; i++) begin
            if (byte_idx_q == IDX_W'(FIFO_RD_BYTE - 1 - i)) begin
                cur_byte = word_q[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
        end else begin
            rd_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        state_q <= S_REQ;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_REQ: begin
                    state_q <= S_LOAD;
                end
                // Read data is valid now, one cycle after the enable pulse.
                S_LOAD: begin
                    word_q     <= fifo_rd_data;
                    byte_idx_q <= '0;
                    baud_cnt_q <= '0;
                    tx_q       <= 1'b0;
                    state_q    <= S_START;
                end
                S_START: begin
                    if (baud_done) begin
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        tx_q       <= cur_byte[0];
                        state_q    <= S_DATA;
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= cur_byte[bit_idx_q + 3'd1];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        baud_cnt_q <= '0;
                        if (byte_idx_q != BYTE_LAST) begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            tx_q       <= 1'b0;
                            state_q    <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    tx_q       <= 1'b1;
                    busy_q     <= 1'b0;
                    baud_cnt_q <= '0;
                end
            endcase
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign tx         = tx_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - randomized self-checking bench: FIFO model plus serial-line frame decoder
// Bit period is 16 clocks (200 Hz clock / 12 baud, truncated) to keep runs short.

module tb_uart_transmitter;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fifo_rd_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        tx;
    logic        busy;

    uart_transmitter #(
        .UART_BPS      (12),
        .CLK_FREQ      (200),
        .FIFO_RD_WIDTH (32),
        .FIFO_RD_BYTE  (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .tx           (tx),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] fq[$];
    bit          toggle_mode = 1'b0;
    int          rd_pulses = 0;
    int          rd_cycle = 0;
    int          busy_cycles = 0;
    int          cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Standard FIFO model: data appears the cycle after a read pulse, random otherwise.
    initial begin
        bit prev_busy = 1'b0;
        bit prev_empty = 1'b1;
        bit empty_at_edge;
        bit rd_seen;
        fifo_empty   = 1'b1;
        fifo_rd_data = $urandom;
        forever begin
            @(negedge clk);
            rd_seen = fifo_rd_en;
            if (busy) busy_cycles++;
            if (rd_seen) begin
                rd_pulses++;
                rd_cycle = cyc;
                check_eq("rd_en_only_from_idle_nonempty", 32'({prev_busy, prev_empty}), 32'd0);
            end
            prev_busy = busy;
            @(posedge clk);
            cyc++;
            empty_at_edge = fifo_empty;
            #1;
            prev_empty = empty_at_edge;
            if (rd_seen) begin
                if (fq.size() == 0) begin
                    check_eq("fifo_underflow", 32'd1, 32'd0);
                    fifo_rd_data = $urandom;
                end else begin
                    fifo_rd_data = fq.pop_front();
                end
            end else begin
                fifo_rd_data = $urandom;
            end
            if (toggle_mode && busy) fifo_empty = ~fifo_empty;
            else fifo_empty = (fq.size() == 0);
        end
    end

    task automatic sync_mid();
        @(posedge clk);
        #2;
    endtask

    // Decode one 8N1 frame from the line; idle = high samples seen before the start bit.
    task automatic recv_byte(output logic [7:0] b, output int idle, output int start_cyc);
        int   t = 0;
        bit   shape_ok = 1'b1;
        logic v;
        idle = 0;
        b = 8'h00;
        start_cyc = 0;
        @(negedge clk);
        while (tx !== 1'b0 && t < 50 * N) begin
            idle++;
            t++;
            @(negedge clk);
        end
        if (tx !== 1'b0) begin
            check_eq("start_bit_timeout", 32'(tx), 32'd0);
            return;
        end
        start_cyc = cyc;
        for (int k = 1; k < N; k++) begin
            @(negedge clk);
            if (tx !== 1'b0) shape_ok = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v = tx;
            b[i] = v;
            for (int k = 1; k < N; k++) begin
                @(negedge clk);
                if (tx !== v) shape_ok = 1'b0;
            end
        end
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) shape_ok = 1'b0;
        end
        check_eq("frame_bit_widths", 32'(shape_ok), 32'd1);
    endtask

    task automatic recv_word(input logic [31:0] w, input int exp_gap);
        logic [7:0]  b;
        logic [31:0] sh;
        int          idle;
        int          sc;
        for (int j = 0; j < 4; j++) begin
            recv_byte(b, idle, sc);
            sh = w >> (24 - 8 * j);
            check_eq("byte_value", 32'(b), 32'(sh[7:0]));
            if (j == 0) begin
                if (exp_gap >= 0) check_eq("word_gap_high_clocks", 32'(idle), 32'(exp_gap));
                check_eq("rd_en_to_start_latency", 32'(sc - rd_cycle), 32'd2);
            end else begin
                check_eq("intra_word_gap", 32'(idle), 32'd0);
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] words[$];
        int          p0;
        bit          bad_tx;
        bit          bad_busy;
        int          t;

        repeat (3) @(negedge clk);
        check_eq("reset_tx", 32'(tx), 32'd1);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        sync_mid();
        rst_n = 1'b1;

        bad_tx = 1'b0;
        bad_busy = 1'b0;
        repeat (2000) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx = 1'b1;
            if (busy !== 1'b0) bad_busy = 1'b1;
        end
        check_eq("empty_idle_tx_high", 32'(bad_tx), 32'd0);
        check_eq("empty_idle_not_busy", 32'(bad_busy), 32'd0);
        check_eq("empty_idle_no_reads", 32'(rd_pulses), 32'd0);

        sync_mid();
        busy_cycles = 0;
        p0 = rd_pulses;
        fq.push_back(32'h12345678);
        recv_word(32'h12345678, -1);
        repeat (5) @(negedge clk);
        check_eq("single_word_busy_clocks", 32'(busy_cycles), 32'(2 + 40 * N));
        check_eq("single_word_reads", 32'(rd_pulses - p0), 32'd1);

        sync_mid();
        p0 = rd_pulses;
        fq.push_back(32'hA5A5A5A5);
        fq.push_back(32'h00FF00FF);
        recv_word(32'hA5A5A5A5, -1);
        recv_word(32'h00FF00FF, 3);
        repeat (5) @(negedge clk);
        check_eq("two_word_reads", 32'(rd_pulses - p0), 32'd2);

        sync_mid();
        w = $urandom;
        fq.push_back(w);
        t = 0;
        @(negedge clk);
        while (tx !== 1'b0 && t < 100) begin
            t++;
            @(negedge clk);
        end
        check_eq("abort_word_started", 32'(tx), 32'd0);
        repeat (24 * N + N / 2) @(negedge clk);
        check_eq("abort_byte2_bit3", 32'(tx), 32'(w[11]));
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_tx_high_same_cycle", 32'(tx), 32'd1);
        check_eq("abort_busy_low", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        sync_mid();
        rst_n = 1'b1;
        p0 = rd_pulses;
        bad_tx = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx = 1'b1;
        end
        check_eq("abort_no_retry_tx", 32'(bad_tx), 32'd0);
        check_eq("abort_no_retry_reads", 32'(rd_pulses - p0), 32'd0);
        sync_mid();
        w = $urandom;
        fq.push_back(w);
        recv_word(w, -1);

        sync_mid();
        p0 = rd_pulses;
        toggle_mode = 1'b1;
        w = $urandom;
        fq.push_back(w);
        recv_word(w, -1);
        repeat (5) @(negedge clk);
        toggle_mode = 1'b0;
        check_eq("toggle_empty_reads", 32'(rd_pulses - p0), 32'd1);

        sync_mid();
        p0 = rd_pulses;
        words.delete();
        for (int i = 0; i < 30; i++) begin
            w = $urandom;
            words.push_back(w);
            fq.push_back(w);
        end
        for (int i = 0; i < 30; i++) recv_word(words[i], (i == 0) ? -1 : 3);
        repeat (5) @(negedge clk);
        check_eq("stream_reads", 32'(rd_pulses - p0), 32'd30);

        p0 = rd_pulses;
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            sync_mid();
            w = $urandom;
            fq.push_back(w);
            recv_word(w, -1);
        end
        repeat (5) @(negedge clk);
        check_eq("gapped_reads", 32'(rd_pulses - p0), 32'd5);
        check_eq("final_idle_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
